nrisc_ddata_arbiter: RTL and testbench

Shares the single D-Data memory port between the NRISC core and one secondary bus master (DMA engine or debug port). The core has absolute priority and is never stalled: its D-Data signals pass combinationally to memory. The secondary master uses a req/gnt handshake and is served only in cycles where the core issues no access. A wait-state FSM with a starvation counter tracks how long the secondary master has been blocked.

---
 rtl/nrisc_ddata_arbiter_pkg.sv | 24 ++
 rtl/nrisc_ddata_arbiter.sv | 158 +++++++++++++++
 tb/tb_nrisc_ddata_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrisc_ddata_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// nrisc_ddata_arbiter_pkg
// Shared constants for the NRISC D-Data port arbiter: default data/address
// widths (kept in step with the core), arbiter FSM state encodings, the
// starvation counter width and the D-Data access size codes the core drives on
// its ctrl lines.
// ---------------------------------------------------------------------------
package nrisc_ddata_arbiter_pkg;

  localparam int TAM_DEF     = 16;  // data word width
  localparam int N_DDATA_DEF = 12;  // D-Data address width
  localparam int CNT_W       = 8;   // starvation counter width

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  // D-Data access size codes shared with the core
  localparam logic [2:0] DSIZE_BYTE = 3'b000;
  localparam logic [2:0] DSIZE_HALF = 3'b001;
  localparam logic [2:0] DSIZE_WORD = 3'b010;

endpackage

// File: rtl/nrisc_ddata_arbiter.sv
// ---------------------------------------------------------------------------
// nrisc_ddata_arbiter
// Shares the single D-Data memory port between the NRISC core (absolute
// priority, zero added latency) and one secondary master (DMA / debug) using a
// req/gnt handshake. The secondary master is granted only in cycles where the
// core makes no access. A two-state wait FSM tracks blocked requests and, when
// NRISC_DARB_STARVE_EN is defined, a saturating counter drives ARB_starve.
// Without NRISC_DARB_STARVE_EN the counter is absent and ARB_starve is 0.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   CORE_*            core D-Data request (addr, wdata, load, write, ctrl)
//   CORE_rdata        read data returned to the core (= MEM_rdata)
//   DMA_req/we/addr/wdata/ctrl   secondary master request
//   DMA_gnt           access performed this cycle (combinational)
//   DMA_rdata/rvalid  read data to secondary master, valid the cycle after
//   MEM_*             the shared memory port
//   ARB_starve        secondary master starved
// ---------------------------------------------------------------------------
module nrisc_ddata_arbiter
  import nrisc_ddata_arbiter_pkg::*;
#(
  parameter int TAM        = TAM_DEF,
  parameter int N_DData    = N_DDATA_DEF,
  parameter int STARVE_LIM = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DData-1:0] CORE_addr,
  input  logic [TAM-1:0]     CORE_wdata,
  input  logic               CORE_load,
  input  logic               CORE_write,
  input  logic [2:0]         CORE_ctrl,
  output logic [TAM-1:0]     CORE_rdata,
  input  logic               DMA_req,
  input  logic               DMA_we,
  input  logic [N_DData-1:0] DMA_addr,
  input  logic [TAM-1:0]     DMA_wdata,
  input  logic [2:0]         DMA_ctrl,
  output logic               DMA_gnt,
  output logic [TAM-1:0]     DMA_rdata,
  output logic               DMA_rvalid,
  output logic [N_DData-1:0] MEM_addr,
  output logic [TAM-1:0]     MEM_wdata,
  output logic               MEM_load,
  output logic               MEM_write,
  output logic [2:0]         MEM_ctrl,
  input  logic [TAM-1:0]     MEM_rdata,
  output logic               ARB_starve
);

  arb_state_e         state_q, state_d;
  logic               core_raw;
  logic               core_act;
  logic               gnt;
  logic [N_DData-1:0] addr_q;
  logic [TAM-1:0]     wdata_q;
  logic [2:0]         ctrl_q;
  logic               rvalid_q;

  // Strobes are qualified with rst so no access reaches memory while reset is
  // held, even though the core path is otherwise purely combinational.
  assign core_raw = CORE_load | CORE_write;
  assign core_act = rst & core_raw;
  assign gnt      = rst & DMA_req & ~core_raw;

  // Read data is broadcast; each master knows whether it is the owner.
  assign CORE_rdata = MEM_rdata;
  assign DMA_rdata  = MEM_rdata;
  assign DMA_rvalid = rvalid_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (DMA_req && core_raw) state_d = ARB_WAIT;
      // Request withdrawn before grant is a protocol violation; recover to IDLE.
      ARB_WAIT: if (gnt || !DMA_req)     state_d = ARB_IDLE;
      default:                           state_d = ARB_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / memory mux ----------------
  always_comb begin
    DMA_gnt   = gnt;
    MEM_load  = 1'b0;
    MEM_write = 1'b0;
    MEM_addr  = addr_q;
    MEM_wdata = wdata_q;
    MEM_ctrl  = ctrl_q;
    if (core_act) begin
      MEM_load  = CORE_load;
      MEM_write = CORE_write;
      MEM_addr  = CORE_addr;
      MEM_wdata = CORE_wdata;
      MEM_ctrl  = CORE_ctrl;
    end else if (gnt) begin
      MEM_load  = ~DMA_we;
      MEM_write = DMA_we;
      MEM_addr  = DMA_addr;
      MEM_wdata = DMA_wdata;
      MEM_ctrl  = DMA_ctrl;
    end
  end

  // Idle cycles keep the last driven address/data/ctrl on the port so memory
  // inputs do not toggle needlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
    end else if (core_act || gnt) begin
      addr_q  <= MEM_addr;
      wdata_q <= MEM_wdata;
      ctrl_q  <= MEM_ctrl;
    end
  end

  // Memory returns read data one cycle after the load strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rvalid_q <= 1'b0;
    else      rvalid_q <= gnt & ~DMA_we;
  end

`ifdef NRISC_DARB_STARVE_EN
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts blocked cycles spent in WAIT; the first blocked cycle (the one that
  // moves IDLE->WAIT) is not counted. Returning to IDLE clears it, so the
  // cleared value appears the cycle after the grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ARB_IDLE)
      cnt_d = '0;
    else if (state_q == ARB_WAIT && !gnt && cnt_q != LIM_C)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign ARB_starve = (cnt_q == LIM_C);
`else
  assign ARB_starve = 1'b0;
`endif

endmodule

// File: tb/tb_nrisc_ddata_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nrisc_ddata_arbiter
// Self-checking bench for nrisc_ddata_arbiter: a combinational vector table,
// hand-written multi-cycle sequences and a randomized run compared with a
// behavioural model (shadow memory, blocked-run length, last driven fields).
// Starvation expectations follow NRISC_DARB_STARVE_EN.
// ---------------------------------------------------------------------------
module tb_nrisc_ddata_arbiter;
  import nrisc_ddata_arbiter_pkg::*;

  localparam int TAM = 16;
  localparam int NA  = 12;
  localparam int LIM = 15;

  logic          clk;
  logic          rst;
  logic [NA-1:0] CORE_addr;
  logic [TAM-1:0] CORE_wdata;
  logic          CORE_load, CORE_write;
  logic [2:0]    CORE_ctrl;
  logic [TAM-1:0] CORE_rdata;
  logic          DMA_req, DMA_we;
  logic [NA-1:0] DMA_addr;
  logic [TAM-1:0] DMA_wdata;
  logic [2:0]    DMA_ctrl;
  logic          DMA_gnt;
  logic [TAM-1:0] DMA_rdata;
  logic          DMA_rvalid;
  logic [NA-1:0] MEM_addr;
  logic [TAM-1:0] MEM_wdata;
  logic          MEM_load, MEM_write;
  logic [2:0]    MEM_ctrl;
  logic [TAM-1:0] MEM_rdata;
  logic          ARB_starve;

  int checks = 0;
  int errors = 0;

  nrisc_ddata_arbiter #(.TAM(TAM), .N_DData(NA), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .CORE_addr(CORE_addr), .CORE_wdata(CORE_wdata), .CORE_load(CORE_load),
    .CORE_write(CORE_write), .CORE_ctrl(CORE_ctrl), .CORE_rdata(CORE_rdata),
    .DMA_req(DMA_req), .DMA_we(DMA_we), .DMA_addr(DMA_addr), .DMA_wdata(DMA_wdata),
    .DMA_ctrl(DMA_ctrl), .DMA_gnt(DMA_gnt), .DMA_rdata(DMA_rdata), .DMA_rvalid(DMA_rvalid),
    .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_load(MEM_load), .MEM_write(MEM_write),
    .MEM_ctrl(MEM_ctrl), .MEM_rdata(MEM_rdata), .ARB_starve(ARB_starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment memory (one-cycle read latency) ----------------
  logic [TAM-1:0] mem [0:(1<<NA)-1];
  logic [TAM-1:0] mem_rdata_r;
  assign MEM_rdata = mem_rdata_r;
  always @(posedge clk) begin
    if (MEM_write) mem[MEM_addr] <= MEM_wdata;
    if (MEM_load)  mem_rdata_r   <= mem[MEM_addr];
  end

  // ---------------- behavioural reference model ----------------
  logic [TAM-1:0] smem [0:(1<<NA)-1];  // what memory should contain
  int             m_run;               // consecutive cycles with req & core busy
  logic           m_rv, m_core_rv;
  logic [TAM-1:0] m_rd, m_core_rd;
  logic [NA-1:0]  m_addr;
  logic [TAM-1:0] m_wdata;
  logic [2:0]     m_ctrl;
  logic           m_busy;
  assign m_busy = CORE_load | CORE_write;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 0; m_rv <= 1'b0; m_core_rv <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_ctrl <= '0;
    end else begin
      m_run     <= (DMA_req && m_busy) ? m_run + 1 : 0;
      m_rv      <= DMA_req && !m_busy && !DMA_we;
      m_core_rv <= CORE_load;
      if (CORE_load) m_core_rd <= smem[CORE_addr];
      if (m_busy) begin
        m_addr <= CORE_addr; m_wdata <= CORE_wdata; m_ctrl <= CORE_ctrl;
        if (CORE_write) smem[CORE_addr] <= CORE_wdata;
      end else if (DMA_req) begin
        m_addr <= DMA_addr; m_wdata <= DMA_wdata; m_ctrl <= DMA_ctrl;
        if (DMA_we) smem[DMA_addr] <= DMA_wdata;
        else        m_rd <= smem[DMA_addr];
      end
    end
  end

  function automatic logic exp_starve_f(input int run);
`ifdef NRISC_DARB_STARVE_EN
    return run > LIM;
`else
    return (run < 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic core_set(input logic ld, input logic wr, input logic [NA-1:0] a, input logic [TAM-1:0] d);
    CORE_load = ld; CORE_write = wr; CORE_addr = a; CORE_wdata = d; CORE_ctrl = DSIZE_WORD;
  endtask

  task automatic dma_set(input logic rq, input logic we, input logic [NA-1:0] a, input logic [TAM-1:0] d);
    DMA_req = rq; DMA_we = we; DMA_addr = a; DMA_wdata = d; DMA_ctrl = DSIZE_HALF;
  endtask

  // full-model check of every output in the current cycle
  task automatic model_check();
    logic eg, el, ew;
    logic [NA-1:0] ea;
    logic [TAM-1:0] ed;
    logic [2:0] ec;
    eg = rst & DMA_req & ~m_busy;
    el = rst & (m_busy ? CORE_load  : (DMA_req & ~DMA_we));
    ew = rst & (m_busy ? CORE_write : (DMA_req &  DMA_we));
    ea = (rst & m_busy) ? CORE_addr  : eg ? DMA_addr  : m_addr;
    ed = (rst & m_busy) ? CORE_wdata : eg ? DMA_wdata : m_wdata;
    ec = (rst & m_busy) ? CORE_ctrl  : eg ? DMA_ctrl  : m_ctrl;
    chk("rnd_gnt", 32'(DMA_gnt), 32'(eg));
    chk("rnd_mem_load", 32'(MEM_load), 32'(el));
    chk("rnd_mem_write", 32'(MEM_write), 32'(ew));
    chk("rnd_mem_addr", 32'(MEM_addr), 32'(ea));
    chk("rnd_mem_wdata", 32'(MEM_wdata), 32'(ed));
    chk("rnd_mem_ctrl", 32'(MEM_ctrl), 32'(ec));
    chk("rnd_rvalid", 32'(DMA_rvalid), 32'(m_rv));
    chk("rnd_starve", 32'(ARB_starve), 32'(rst & exp_starve_f(m_run)));
    if (m_rv) chk("rnd_dma_rdata", 32'(DMA_rdata), 32'(m_rd));
    if (rst && m_core_rv) chk("rnd_core_rdata", 32'(CORE_rdata), 32'(m_core_rd));
  endtask

  typedef struct {
    logic rst, ld, wr, req, we;
    logic e_gnt, e_ld, e_wr;
  } vec_t;

  vec_t vt [8];
  logic exp_st;
  logic pend;
  int   op;
  int   busy_pct;

  initial begin
    for (int i = 0; i < (1 << NA); i++) begin
      mem[i]  = TAM'(i) ^ 16'hA5A5;
      smem[i] = TAM'(i) ^ 16'hA5A5;
    end
    mem[12'h010]  = 16'hBEEF;
    smem[12'h010] = 16'hBEEF;

    // ---------------- reset ----------------
    rst = 1'b0;
    core_set(1'b0, 1'b0, '0, '0);
    dma_set(1'b1, 1'b0, 12'h010, '0);
    #2;
    chk("reset_gnt", 32'(DMA_gnt), 0);
    chk("reset_rvalid", 32'(DMA_rvalid), 0);
    chk("reset_mem_load", 32'(MEM_load), 0);
    chk("reset_mem_write", 32'(MEM_write), 0);
    chk("reset_starve", 32'(ARB_starve), 0);
    chk("reset_mem_addr", 32'(MEM_addr), 0);
    $display("reset: gnt=%0b rvalid=%0b load=%0b write=%0b starve=%0b", DMA_gnt, DMA_rvalid, MEM_load, MEM_write, ARB_starve);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; dma_set(1'b0, 1'b0, '0, '0);

    // ---------------- combinational vector table ----------------
    //        rst   ld    wr    req   we    gnt   ld    wr
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = vt[i].rst;
      core_set(vt[i].ld, vt[i].wr, 12'h3F0, 16'h0F0F);
      dma_set(vt[i].req, vt[i].we, 12'h3F1, 16'hF0F0);
      #2;
      chk("vec_gnt", 32'(DMA_gnt), 32'(vt[i].e_gnt));
      chk("vec_mem_load", 32'(MEM_load), 32'(vt[i].e_ld));
      chk("vec_mem_write", 32'(MEM_write), 32'(vt[i].e_wr));
      $display("vector %0d: gnt=%0b load=%0b write=%0b", i, DMA_gnt, MEM_load, MEM_write);
    end
    @(negedge clk);
    rst = 1'b1; core_set(1'b0, 1'b0, '0, '0); dma_set(1'b0, 1'b0, '0, '0);

    // ---------------- uncontended read ----------------
    @(negedge clk); dma_set(1'b1, 1'b0, 12'h010, '0); #2;
    chk("unc_gnt", 32'(DMA_gnt), 1);
    chk("unc_mem_addr", 32'(MEM_addr), 32'h010);
    chk("unc_mem_load", 32'(MEM_load), 1);
    @(negedge clk); dma_set(1'b0, 1'b0, '0, '0); #2;
    chk("unc_rvalid", 32'(DMA_rvalid), 1);
    chk("unc_rdata", 32'(DMA_rdata), 32'hBEEF);
    $display("uncontended read: rvalid=%0b rdata=%h", DMA_rvalid, DMA_rdata);
    @(negedge clk); #2;
    chk("unc_rvalid_drop", 32'(DMA_rvalid), 0);
    chk("unc_addr_held", 32'(MEM_addr), 32'h010);

    // ---------------- contention ----------------
    @(negedge clk);
    core_set(1'b0, 1'b1, 12'h020, 16'h1234);
    dma_set(1'b1, 1'b1, 12'h020, 16'h5555); #2;
    chk("cont_gnt", 32'(DMA_gnt), 0);
    chk("cont_mem_write", 32'(MEM_write), 1);
    chk("cont_mem_wdata", 32'(MEM_wdata), 32'h1234);
    @(negedge clk); core_set(1'b0, 1'b0, '0, '0); #2;
    chk("cont_gnt2", 32'(DMA_gnt), 1);
    chk("cont_mem_wdata2", 32'(MEM_wdata), 32'h5555);
    @(negedge clk); dma_set(1'b1, 1'b0, 12'h020, '0); #2;
    chk("cont_mem_final", 32'(mem[12'h020]), 32'h5555);
    @(negedge clk); dma_set(1'b0, 1'b0, '0, '0); #2;
    chk("cont_readback", 32'(DMA_rdata), 32'h5555);
    $display("contention: memory[020]=%h", mem[12'h020]);

    // ---------------- starvation ----------------
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      core_set(1'b1, 1'b0, 12'h000, '0);
      dma_set(1'b1, 1'b0, 12'h030, '0); #2;
      exp_st = 1'b0;
`ifdef NRISC_DARB_STARVE_EN
      exp_st = (i >= LIM + 1);
`endif
      chk("starve_blocked", 32'(ARB_starve), 32'(exp_st));
      chk("starve_gnt", 32'(DMA_gnt), 0);
    end
    @(negedge clk); core_set(1'b0, 1'b0, '0, '0); #2;
    chk("starve_release_gnt", 32'(DMA_gnt), 1);
`ifdef NRISC_DARB_STARVE_EN
    chk("starve_grant_cycle", 32'(ARB_starve), 1);
`endif
    @(negedge clk); dma_set(1'b0, 1'b0, '0, '0); #2;
    chk("starve_after_grant", 32'(ARB_starve), 0);
    $display("starvation: released, starve=%0b", ARB_starve);

    // ---------------- back-to-back reads ----------------
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) dma_set(1'b1, 1'b0, NA'(i), '0);
      else       dma_set(1'b0, 1'b0, '0, '0);
      #2;
      if (i < 4) chk("b2b_gnt", 32'(DMA_gnt), 1);
      if (i > 0) begin
        chk("b2b_rvalid", 32'(DMA_rvalid), 1);
        chk("b2b_rdata", 32'(DMA_rdata), 32'(16'hA5A5 ^ 16'(i - 1)));
        $display("back-to-back read %0d: rdata=%h", i - 1, DMA_rdata);
      end
    end
    @(negedge clk); #2;
    chk("b2b_rvalid_end", 32'(DMA_rvalid), 0);

    // ---------------- core read then DMA read ----------------
    @(negedge clk); core_set(1'b1, 1'b0, 12'h005, '0); #2;
    @(negedge clk); core_set(1'b0, 1'b0, '0, '0); dma_set(1'b1, 1'b0, 12'h006, '0); #2;
    chk("mix_core_rdata", 32'(CORE_rdata), 32'hA5A0);
    chk("mix_gnt", 32'(DMA_gnt), 1);
    @(negedge clk); dma_set(1'b0, 1'b0, '0, '0); #2;
    chk("mix_dma_rdata", 32'(DMA_rdata), 32'hA5A3);
    chk("mix_rvalid", 32'(DMA_rvalid), 1);
    $display("core-then-dma: dma rdata=%h", DMA_rdata);

    // ---------------- mid-operation reset ----------------
    @(negedge clk); dma_set(1'b1, 1'b0, 12'h011, '0); #2;
    chk("mid_gnt", 32'(DMA_gnt), 1);
    @(negedge clk); rst = 1'b0; dma_set(1'b0, 1'b0, '0, '0); #2;
    chk("mid_rvalid_dropped", 32'(DMA_rvalid), 0);
    chk("mid_addr_cleared", 32'(MEM_addr), 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); core_set(1'b0, 1'b1, 12'h3F2, 16'h0001); dma_set(1'b1, 1'b1, 12'h3F3, 16'h0002); #2;
    end
    exp_st = 1'b0;
`ifdef NRISC_DARB_STARVE_EN
    exp_st = 1'b1;
`endif
    chk("midwait_starve", 32'(ARB_starve), 32'(exp_st));
    @(negedge clk); rst = 1'b0; #2;
    chk("midwait_reset_starve", 32'(ARB_starve), 0);
    chk("midwait_reset_gnt", 32'(DMA_gnt), 0);
    @(negedge clk); rst = 1'b1; core_set(1'b0, 1'b0, '0, '0); #2;
    chk("midwait_post_gnt", 32'(DMA_gnt), 1);
    chk("midwait_post_starve", 32'(ARB_starve), 0);
    $display("mid-operation reset: starve=%0b gnt=%0b", ARB_starve, DMA_gnt);
    @(negedge clk); dma_set(1'b0, 1'b0, '0, '0);

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      pend = DMA_req && (m_busy || !rst);
      rst = ($urandom_range(0, 199) != 0);
      busy_pct = ((n / 300) % 2 == 1) ? 95 : 40;
      op = ($urandom_range(0, 99) < busy_pct) ? int'($urandom_range(1, 2)) : 0;
      CORE_load  = (op == 1);
      CORE_write = (op == 2);
      CORE_addr  = NA'($urandom_range(0, 31));
      CORE_wdata = TAM'($urandom);
      CORE_ctrl  = 3'($urandom_range(0, 2));
      if (!(pend && $urandom_range(0, 49) != 0)) begin
        DMA_req   = ($urandom_range(0, 99) < 70);
        DMA_we    = $urandom_range(0, 1) == 1;
        DMA_addr  = NA'($urandom_range(0, 31));
        DMA_wdata = TAM'($urandom);
        DMA_ctrl  = 3'($urandom_range(0, 2));
      end
      #2;
      model_check();
    end
    $display("random run: %0d cycles", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
